// File: rtl/dmem_bytelane.sv
// dmem_bytelane: RV32 data memory with byte/half/word load-store sizing,
// a req/ready/valid handshake, a zeroing sweep after reset and an address
// range check. A request accepted on edge N returns d_valid/d_out/d_err
// after edge N+1. Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned
// half/word accesses into errors instead of aligning them down.
module dmem_bytelane #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_add,
    input  logic [31:0]       data_in,
    output logic              d_ready,
    output logic              d_valid,
    output logic [31:0]       d_out,
    output logic              d_err,
    output logic              init_done
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-3:0] DEPTH_A = (ADDR_W - 2)'(DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  ptr;
    logic              ready;
    logic              accept;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-3:0] widx;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              bad;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;

    logic              vld_p0;
    logic              err_p0;
    logic [31:0]       ld_p0;
    logic              vld_p1;
    logic              err_p1;
    logic [31:0]       out_p1;

    // Extract the addressed byte/half from a word and extend it per funct3.
    // The half lane is taken from lane[1] only, so halfwords are aligned down.
    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    assign widx     = d_add[ADDR_W-1:2];
    assign idx      = widx[IDX_W-1:0];
    assign in_range = (widx < DEPTH_A);
    assign rd_word  = mem[idx];

    // Request decode: byte enables, replicated store data and the error flag.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'd0;
        bad   = ~in_range;
        case (d_funct3)
            3'b000: begin
                be    = 4'b0001 << d_add[1:0];
                wdata = {4{data_in[7:0]}};
            end
            3'b001: begin
                be    = d_add[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_in[15:0]}};
            end
            3'b010: begin
                be    = 4'b1111;
                wdata = data_in;
            end
            3'b100, 3'b101: bad = bad | d_we;
            default:        bad = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((d_funct3[1:0] == 2'b01) && d_add[0])
            bad = 1'b1;
        if ((d_funct3 == 3'b010) && (d_add[1:0] != 2'b00))
            bad = 1'b1;
`endif
    end

    // Next-state and ready: CLEAR sweeps until the last word, IDLE serves.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            CLEAR:   if (ptr == LAST) state_nx = IDLE;
            IDLE:    ready = 1'b1;
            default: state_nx = CLEAR;
        endcase
    end

    assign accept    = d_req & ready;
    assign d_ready   = ready;
    assign init_done = (state == IDLE);

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            if ((state == CLEAR) && (ptr != LAST))
                ptr <= ptr + IDX_W'(1);
        end
    end

    // Memory array: zero sweep in CLEAR, byte-lane writes for accepted stores.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= 32'd0;
        end else if (accept && d_we && !bad) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // ---- stage p0: capture accept, error and extracted load data ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            err_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            err_p0 <= accept & bad;
        end
    end

    // Load data for the accepted request; zero for stores and errors.
    always_ff @(posedge clk) begin
        if (accept)
            ld_p0 <= (bad || d_we) ? 32'd0 : load_ext(d_funct3, rd_word, d_add[1:0]);
    end

    // ---- stage p1: response registers, d_out forced to 0 when idle ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            out_p1 <= 32'd0;
        end else begin
            vld_p1 <= vld_p0;
            err_p1 <= err_p0;
            out_p1 <= vld_p0 ? ld_p0 : 32'd0;
        end
    end

    assign d_valid = vld_p1;
    assign d_err   = err_p1;
    assign d_out   = out_p1;

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: directed bench for dmem_bytelane (DEPTH=16) with a
// word-array reference model and a per-cycle compare process; literal
// expectations ride in a response queue matched against each d_valid.
module tb_dmem_bytelane;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_add;
    logic [31:0] data_in;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_out;
    logic        d_err;
    logic        init_done;

    int tests = 0;
    int fails = 0;

    dmem_bytelane #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
        .d_add(d_add), .data_in(data_in), .d_ready(d_ready), .d_valid(d_valid),
        .d_out(d_out), .d_err(d_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m [DEPTH];
    bit          started = 0;
    int          clr = 0;
    bit          m_ready = 0;
    bit          mp_v = 0, ev = 0;
    logic [31:0] mp_o = 0, eo = 0;
    bit          mp_e = 0, ee = 0;

    // Literal-expectation queue, one entry per issued request
    bit          lq_chk[$];
    logic [31:0] lq_out[$];
    bit          lq_err[$];
    int          lq_id[$];

    // Compute the response of one accepted request and apply stores.
    task automatic model_access(output logic [31:0] o, output bit e);
        int unsigned idx;
        int unsigned l;
        logic [31:0] w, v;
        idx = d_add >> 2;
        l   = d_add % 4;
        e   = (idx >= DEPTH) || (d_funct3 == 3) || (d_funct3 == 6) || (d_funct3 == 7)
              || (d_we && (d_funct3 == 4 || d_funct3 == 5));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((d_funct3 == 1 || d_funct3 == 5) && (l % 2 != 0)) e = 1;
        if (d_funct3 == 2 && l != 0) e = 1;
`else
        if (d_funct3 == 1 || d_funct3 == 5) l = l - (l % 2);
        if (d_funct3 == 2) l = 0;
`endif
        o = 0;
        if (!e) begin
            w = m[idx];
            if (d_we) begin
                if (d_funct3 == 0)      m[idx] = (w & ~(32'hFF << (8*l)))   | ((data_in & 32'hFF)   << (8*l));
                else if (d_funct3 == 1) m[idx] = (w & ~(32'hFFFF << (8*l))) | ((data_in & 32'hFFFF) << (8*l));
                else                    m[idx] = data_in;
            end else begin
                if (d_funct3 == 0 || d_funct3 == 4) begin
                    v = (w >> (8*l)) & 32'hFF;
                    o = (d_funct3 == 0 && v >= 128) ? v - 32'd256 : v;
                end else if (d_funct3 == 1 || d_funct3 == 5) begin
                    v = (w >> (8*l)) & 32'hFFFF;
                    o = (d_funct3 == 1 && v >= 32768) ? v - 32'd65536 : v;
                end else begin
                    o = w;
                end
            end
        end
    endtask

    // Model: memory reads as zero once cleared; response two edges after accept.
    always @(posedge clk) begin
        if (!rst) begin
            started = 1;
            clr = 0;
            mp_v = 0; mp_o = 0; mp_e = 0;
            ev = 0; eo = 0; ee = 0;
            for (int i = 0; i < DEPTH; i++) m[i] = 0;
        end else if (started) begin
            ev = mp_v; eo = mp_o; ee = mp_e;
            mp_v = 0; mp_o = 0; mp_e = 0;
            if (clr < DEPTH) clr++;
            else if (d_req) begin
                model_access(mp_o, mp_e);
                mp_v = 1;
            end
        end
        m_ready = started && (clr >= DEPTH);
    end

    // Per-cycle compare against the model, plus queued literal checks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                chk("d_ready", d_ready, m_ready);
                chk("init_done", init_done, m_ready);
                chk("d_valid", d_valid, ev);
                chk("d_out", d_out, eo);
                chk("d_err", d_err, ee);
                if (!rst) begin
                    lq_chk.delete(); lq_out.delete(); lq_err.delete(); lq_id.delete();
                end else if (d_valid) begin
                    chk("resp_pending", (lq_chk.size() > 0), 1);
                    if (lq_chk.size() > 0) begin
                        if (lq_chk[0]) begin
                            chk($sformatf("lit%0d_out", lq_id[0]), d_out, lq_out[0]);
                            chk($sformatf("lit%0d_err", lq_id[0]), d_err, lq_err[0]);
                        end
                        void'(lq_chk.pop_front()); void'(lq_out.pop_front());
                        void'(lq_err.pop_front()); void'(lq_id.pop_front());
                    end
                end
            end
        end
    end

    int lit_n = 0;

    // Drive one request for one cycle (called at a falling edge).
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit c, input logic [31:0] xo, input bit xe);
        d_req = 1; d_we = we; d_funct3 = f3; d_add = a; data_in = d;
        lq_chk.push_back(c); lq_out.push_back(xo); lq_err.push_back(xe); lq_id.push_back(lit_n);
        lit_n++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        d_req = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_init();
        int cnt;
        cnt = 0;
        while (!d_ready && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("clear_cycles", cnt, 16);
    endtask

    initial begin
        rst = 0; d_req = 0; d_we = 0; d_funct3 = 0; d_add = 0; data_in = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        wait_init();

        issue(0, 3'b010, 32'h3C, 0, 1, 32'h0, 0);
        issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
        issue(1, 3'b000, 32'h11, 32'h00000055, 1, 32'h0, 0);
        issue(0, 3'b010, 32'h10, 0, 1, 32'hDEAD55EF, 0);
        issue(0, 3'b000, 32'h11, 0, 1, 32'h00000055, 0);
        issue(0, 3'b100, 32'h13, 0, 1, 32'h000000DE, 0);
        issue(0, 3'b000, 32'h13, 0, 1, 32'hFFFFFFDE, 0);
        idle(1);
        issue(1, 3'b001, 32'h22, 32'h00008001, 1, 32'h0, 0);
        issue(0, 3'b001, 32'h22, 0, 1, 32'hFFFF8001, 0);
        issue(0, 3'b101, 32'h22, 0, 1, 32'h00008001, 0);
        idle(2);

        // Range and funct3 errors
        issue(0, 3'b010, 32'h40, 0, 1, 32'h0, 1);
        issue(1, 3'b010, 32'h40, 32'h12345678, 1, 32'h0, 1);
        issue(0, 3'b011, 32'h00, 0, 1, 32'h0, 1);
        issue(1, 3'b100, 32'h04, 32'hFFFFFFFF, 1, 32'h0, 1);
        issue(0, 3'b010, 32'h00, 0, 1, 32'h0, 0);
        issue(0, 3'b010, 32'h04, 0, 1, 32'h0, 0);
        for (int i = 0; i < DEPTH; i++) issue(0, 3'b010, i * 4, 0, 0, 0, 0);

        // Misaligned half/word
        issue(1, 3'b010, 32'h20, 32'hCAFEF00D, 1, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(0, 3'b001, 32'h21, 0, 1, 32'h0, 1);
        issue(1, 3'b010, 32'h2B, 32'h11223344, 1, 32'h0, 1);
        issue(0, 3'b010, 32'h28, 0, 1, 32'h0, 0);
`else
        issue(0, 3'b001, 32'h21, 0, 1, 32'hFFFFF00D, 0);
        issue(1, 3'b010, 32'h2B, 32'h11223344, 1, 32'h0, 0);
        issue(0, 3'b010, 32'h28, 0, 1, 32'h11223344, 0);
`endif
        idle(3);
        chk("queue_drained", lq_chk.size(), 0);

        // Reset right after a load is accepted; requests held during the sweep
        issue(0, 3'b010, 32'h10, 0, 1, 32'hDEAD55EF, 0);
        rst = 0;
        @(negedge clk);
        rst = 1;
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_add = 32'h10;
        wait_init();
        d_req = 0;
        issue(0, 3'b010, 32'h10, 0, 1, 32'h0, 0);
        issue(0, 3'b010, 32'h20, 0, 1, 32'h0, 0);
        idle(4);
        chk("queue_drained_end", lq_chk.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
